// File: rtl/io_block_pkg.sv
// Shared definitions for the configurable pad I/O block.
//   pad_mode_e        : per-pad mode encoding held in the active configuration
//   CFG_BITS_PER_PAD  : configuration bits owned by each pad ({reg_out, mode[1:0]})
package io_block_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_IN    = 2'b01,
    MODE_OUT   = 2'b10,
    MODE_BIDIR = 2'b11
  } pad_mode_e;

  localparam int CFG_BITS_PER_PAD = 3;

endpackage

// File: rtl/io_pad_cell.sv
// Single bidirectional pad: tristate driver, optional output/OE registers and
// a pad-to-fabric synchroniser.
//   clk, rst_n          : clock, async active-low reset
//   mode_i, reg_out_i   : active configuration for this pad
//   fab_out_i, fab_oe_i : fabric data and output enable (OE used in bidir only)
//   fab_in_o            : synchronised pad value, forced 0 unless mode is in/bidir
//   pad_io              : external pin
module io_pad_cell
  import io_block_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  pad_mode_e mode_i,
  input  logic      reg_out_i,
  input  logic      fab_out_i,
  input  logic      fab_oe_i,
  output logic      fab_in_o,
  inout  wire       pad_io
);

  logic                   out_q;
  logic                   oe_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pad_oe;
  logic                   pad_dout;

  // Output registers always track the fabric; reg_out only selects whether
  // the pad sees the registered or the direct copy.  The synchroniser keeps
  // running across mode changes, so stale stages may drain out afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= 1'b0;
      oe_q   <= 1'b0;
      sync_q <= '0;
    end else begin
      out_q  <= fab_out_i;
      oe_q   <= fab_oe_i;
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_io};
    end
  end

  always_comb begin
    pad_oe = 1'b0;
    case (mode_i)
      MODE_OUT:   pad_oe = 1'b1;
      MODE_BIDIR: pad_oe = reg_out_i ? oe_q : fab_oe_i;
      default:    pad_oe = 1'b0;
    endcase
  end

  assign pad_dout = reg_out_i ? out_q : fab_out_i;
  assign pad_io   = pad_oe ? pad_dout : 1'bz;

  assign fab_in_o = ((mode_i == MODE_IN) || (mode_i == MODE_BIDIR)) ?
                    sync_q[SYNC_STAGES-1] : 1'b0;

endmodule

// File: rtl/cfg_io_block.sv
// Configurable pad I/O block with a serial configuration chain.
//   clk, rst_n       : clock, async active-low reset
//   cfg_en, cfg_si   : shift enable and serial data into the shadow chain
//   cfg_commit       : copy shadow to active config (only after exactly CW bits)
//   cfg_so           : shadow MSB, for daisy-chaining
//   cfg_err          : sticky flag, set by a rejected commit
//   pad              : external pins
//   fab_out, fab_oe  : fabric data / output enable per pad
//   fab_in           : synchronised pad values to the fabric
// Pad k owns config bits [3k+2:3k]: [3k+1:3k] mode, [3k+2] reg_out.
module cfg_io_block
  import io_block_pkg::*;
#(
  parameter int N_PADS      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic              cfg_si,
  input  logic              cfg_commit,
  output logic              cfg_so,
  output logic              cfg_err,
  inout  wire  [N_PADS-1:0] pad,
  input  logic [N_PADS-1:0] fab_out,
  input  logic [N_PADS-1:0] fab_oe,
  output logic [N_PADS-1:0] fab_in
);

  localparam int CW    = CFG_BITS_PER_PAD * N_PADS;
  localparam int CNT_W = $clog2(CW + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CW);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CW + 1);

  logic [CW-1:0]    shadow_q, shadow_d;
  logic [CW-1:0]    active_q, active_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // A commit always restarts the bit count, whether accepted or not.  A
  // commit coinciding with a shift is rejected but the shift still happens.
  // Counting saturates one past CW so an over-long stream can never wrap
  // back onto a valid count.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    count_d  = count_q;
    err_d    = err_q;
    if (cfg_en) begin
      shadow_d = {shadow_q[CW-2:0], cfg_si};
      if (count_q != CNT_SAT) begin
        count_d = count_q + 1'b1;
      end
    end
    if (cfg_commit) begin
      count_d = '0;
      if (!cfg_en && (count_q == CNT_FULL)) begin
        active_d = shadow_q;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign cfg_so  = shadow_q[CW-1];
  assign cfg_err = err_q;

  for (genvar k = 0; k < N_PADS; k++) begin : g_pad
    pad_mode_e pad_mode;
    assign pad_mode = pad_mode_e'(active_q[CFG_BITS_PER_PAD*k +: 2]);

    io_pad_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_i    (pad_mode),
      .reg_out_i (active_q[CFG_BITS_PER_PAD*k + 2]),
      .fab_out_i (fab_out[k]),
      .fab_oe_i  (fab_oe[k]),
      .fab_in_o  (fab_in[k]),
      .pad_io    (pad[k])
    );
  end

endmodule

// File: tb/tb_cfg_io_block.sv
module tb_cfg_io_block;

  logic       clk;
  logic       rst_n;
  logic       cfg_en;
  logic       cfg_si;
  logic       cfg_commit;
  logic       cfg_so;
  logic       cfg_err;
  wire  [2:0] pad;
  logic [2:0] fab_out;
  logic [2:0] fab_oe;
  logic [2:0] fab_in;

  // External pad drivers (tristate) used to feed inputs and to probe hi-Z.
  logic [2:0] ext_en;
  logic [2:0] ext_val;

  int errors;
  int checks;

  // Model of the shadow chain, used for cfg_so expectations.
  logic [8:0] sh;

  for (genvar k = 0; k < 3; k++) begin : g_ext
    assign pad[k] = ext_en[k] ? ext_val[k] : 1'bz;
  end

  cfg_io_block #(
    .N_PADS      (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .cfg_si     (cfg_si),
    .cfg_commit (cfg_commit),
    .cfg_so     (cfg_so),
    .cfg_err    (cfg_err),
    .pad        (pad),
    .fab_out    (fab_out),
    .fab_oe     (fab_oe),
    .fab_in     (fab_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift n bits of 'bits', MSB of the n-bit field first.
  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_en = 1'b1;
      cfg_si = bits[i];
      tick();
      sh = {sh[7:0], bits[i]};
    end
    cfg_en = 1'b0;
    cfg_si = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ext_en  = 3'b111;
    ext_val = 3'b000;
    fab_out = 3'b111;
    fab_oe  = 3'b111;
    #12;
    if (pad !== 3'b000) begin
      errors++; $display("FAIL reset_hiz_lo: pad=%b want 000", pad);
    end
    checks++;
    ext_val = 3'b111;
    fab_out = 3'b000;
    #1;
    if (pad !== 3'b111) begin
      errors++; $display("FAIL reset_hiz_hi: pad=%b want 111", pad);
    end
    checks++;
    if (fab_in !== 3'b000) begin
      errors++; $display("FAIL reset_fab_in: fab_in=%b want 000", fab_in);
    end
    checks++;
    if (cfg_so !== 1'b0 || cfg_err !== 1'b0) begin
      errors++; $display("FAIL reset_cfg: so=%b err=%b want 0 0", cfg_so, cfg_err);
    end
    checks++;
    tick();
    rst_n = 1'b1;
    fab_oe = 3'b000;
    ext_val = 3'b000;
    tick();
  endtask

  task automatic test_basic_config();
    fab_out = 3'b110;
    ext_en  = 3'b111;
    ext_val = 3'b000;
    shift_bits(32'b000_010_001, 9);
    if (pad !== 3'b000) begin
      errors++; $display("FAIL pre_commit_hiz: pad=%b want 000", pad);
    end
    checks++;
    if (cfg_so !== sh[8]) begin
      errors++; $display("FAIL basic_so: so=%b want %b", cfg_so, sh[8]);
    end
    checks++;
    cfg_commit = 1'b1;
    ext_en  = 3'b101;
    ext_val = 3'b001;
    tick();
    cfg_commit = 1'b0;
    if (pad[2:1] !== 2'b01) begin
      errors++; $display("FAIL commit_drive: pad[2:1]=%b want 01", pad[2:1]);
    end
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL commit_err: err=%b want 0", cfg_err);
    end
    checks++;
    if (fab_in !== 3'b000) begin
      errors++; $display("FAIL sync_stage1: fab_in=%b want 000", fab_in);
    end
    checks++;
    tick();
    if (fab_in !== 3'b001) begin
      errors++; $display("FAIL sync_stage2: fab_in=%b want 001", fab_in);
    end
    checks++;
    fab_out = 3'b100;
    #1;
    if (pad[1] !== 1'b0) begin
      errors++; $display("FAIL comb_out: pad[1]=%b want 0", pad[1]);
    end
    checks++;
  endtask

  task automatic test_short_and_long();
    fab_out = 3'b010;
    shift_bits(32'hFF, 8);
    commit();
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL short_err: err=%b want 1", cfg_err);
    end
    checks++;
    if (pad[1] !== 1'b1 || fab_in !== 3'b001) begin
      errors++; $display("FAIL short_keep: pad[1]=%b fab_in=%b want 1 001", pad[1], fab_in);
    end
    checks++;
    shift_bits(32'h1FF_FFFF, 25);
    commit();
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL long_err: err=%b want 1", cfg_err);
    end
    checks++;
    fab_oe  = 3'b000;
    fab_out = 3'b000;
    shift_bits(32'b000_000_111, 9);
    ext_en  = 3'b110;
    ext_val = 3'b000;
    commit();
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL recommit_err: err=%b want 0", cfg_err);
    end
    checks++;
  endtask

  task automatic test_bidir_reg();
    tick();
    fab_oe[0]  = 1'b1;
    fab_out[0] = 1'b1;
    #2;
    if (pad[0] === 1'b1) begin
      errors++; $display("FAIL bidir_early: pad[0]=%b want not 1", pad[0]);
    end
    checks++;
    tick();
    if (pad[0] !== 1'b1) begin
      errors++; $display("FAIL bidir_lat1: pad[0]=%b want 1", pad[0]);
    end
    checks++;
    tick();
    if (fab_in[0] === 1'b1) begin
      errors++; $display("FAIL loop_early: fab_in[0]=%b want not 1", fab_in[0]);
    end
    checks++;
    tick();
    if (fab_in !== 3'b001) begin
      errors++; $display("FAIL loopback: fab_in=%b want 001", fab_in);
    end
    checks++;
  endtask

  task automatic test_back_to_back_conflict();
    logic [8:0] seq;
    seq = 9'b101_100_110;
    for (int i = 8; i >= 0; i--) begin
      cfg_en     = 1'b1;
      cfg_si     = seq[i];
      cfg_commit = (i == 8);
      tick();
      sh = {sh[7:0], seq[i]};
      if (cfg_so !== sh[8]) begin
        errors++; $display("FAIL conflict_so bit %0d: so=%b want %b", i, cfg_so, sh[8]);
      end
      checks++;
    end
    cfg_en     = 1'b0;
    cfg_commit = 1'b0;
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL conflict_err: err=%b want 1", cfg_err);
    end
    checks++;
    if (pad[0] !== 1'b1 || pad[2:1] !== 2'b00) begin
      errors++; $display("FAIL conflict_keep: pad=%b want 001", pad);
    end
    checks++;
    commit();
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL conflict_count: err=%b want 1", cfg_err);
    end
    checks++;
  endtask

  task automatic test_reset_mid_shift();
    fab_oe  = 3'b000;
    fab_out = 3'b011;
    ext_en  = 3'b100;
    ext_val = 3'b000;
    shift_bits(32'b000_010_010, 9);
    commit();
    if (pad !== 3'b011 || cfg_err !== 1'b0) begin
      errors++; $display("FAIL pre_reset_cfg: pad=%b err=%b want 011 0", pad, cfg_err);
    end
    checks++;
    shift_bits(32'b1010, 4);
    #3;
    rst_n   = 1'b0;
    ext_en  = 3'b111;
    ext_val = 3'b000;
    fab_out = 3'b111;
    sh      = '0;
    #1;
    if (pad !== 3'b000) begin
      errors++; $display("FAIL midreset_hiz: pad=%b want 000", pad);
    end
    checks++;
    if (fab_in !== 3'b000 || cfg_so !== 1'b0) begin
      errors++; $display("FAIL midreset_state: fab_in=%b so=%b want 000 0", fab_in, cfg_so);
    end
    checks++;
    tick();
    rst_n = 1'b1;
    tick();
    commit();
    if (cfg_err !== 1'b1) begin
      errors++; $display("FAIL midreset_commit: err=%b want 1", cfg_err);
    end
    checks++;
    if (pad !== 3'b000) begin
      errors++; $display("FAIL midreset_cfg: pad=%b want 000", pad);
    end
    checks++;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    sh         = '0;
    rst_n      = 1'b0;
    cfg_en     = 1'b0;
    cfg_si     = 1'b0;
    cfg_commit = 1'b0;
    fab_out    = 3'b000;
    fab_oe     = 3'b000;
    ext_en     = 3'b111;
    ext_val    = 3'b000;
    test_reset();
    test_basic_config();
    test_short_and_long();
    test_bidir_reg();
    test_back_to_back_conflict();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_io_block.md
CFG_IO_BLOCK -- requirements
Module: cfg_io_block

Interface
REQ-001 Parameter N_PADS, default 3: number of bidirectional pads.
REQ-002 Parameter SYNC_STAGES, default 2 (min 2): flops in each pad-to-fabric input synchroniser.
REQ-003 Derived constant CW = 3*N_PADS: configuration bits; pad k owns bits [3k+2:3k]; [3k+1:3k] = mode, [3k+2] = reg_out.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port cfg_en, input, 1: shift-enable for the serial configuration chain.
REQ-007 Port cfg_si, input, 1: configuration serial data in.
REQ-008 Port cfg_commit, input, 1: single-cycle request to copy the shadow chain to the active configuration.
REQ-009 Port cfg_so, output, 1: configuration serial data out (chain MSB), for daisy-chaining blocks.
REQ-010 Port cfg_err, output, 1: sticky flag for a rejected commit.
REQ-011 Port pad, inout, N_PADS: external pins.
REQ-012 Port fab_out, input, N_PADS: fabric data to drive onto pads.
REQ-013 Port fab_oe, input, N_PADS: fabric output enable, used only in bidir mode.
REQ-014 Port fab_in, output, N_PADS: synchronised pad value to fabric.

Function
REQ-015 Mode encoding SHALL be 00 off (hi-Z, fab_in=0), 01 input, 10 output (always driven), 11 bidir (driven when fab_oe).
REQ-016 When cfg_en=1, the shadow register SHALL shift as shadow <= {shadow[CW-2:0], cfg_si}, and cfg_so SHALL equal shadow[CW-1].
REQ-017 A bit counter SHALL increment per shifted bit and saturate at CW+1.
REQ-018 On cfg_commit=1 with cfg_en=0 and count==CW, the active config SHALL load from shadow at that edge, cfg_err SHALL clear, and the count SHALL reset to 0.
REQ-019 On cfg_commit=1 with count!=CW, or with cfg_en=1 in the same cycle, the active config SHALL be unchanged, cfg_err SHALL set, and the count SHALL reset to 0.
REQ-020 cfg_err SHALL hold until the next successful commit or reset.
REQ-021 The shadow register SHALL NOT be cleared by commit; the active config SHALL change only on a commit.
REQ-022 A new active config SHALL affect pad drive and fab_in in the cycle immediately after the commit edge.
REQ-023 reg_out=0: pad data = fab_out and enable = mode-derived OE, both combinational.
REQ-024 reg_out=1: fab_out and fab_oe SHALL each be registered, giving exactly 1-cycle latency to the pad.
REQ-025 Pad drive SHALL be hi-Z whenever the enable is 0; no pad SHALL be driven in modes 00 or 01.
REQ-026 Modes 01/11: fab_in SHALL equal the pad value delayed by SYNC_STAGES cycles. Modes 00/10: fab_in SHALL be 0, forced combinationally from the active mode.
REQ-027 Bidir loopback (mode 11, OE=1) SHALL return the driven value on fab_in after SYNC_STAGES cycles.
REQ-028 A mode change SHALL NOT flush the synchroniser; stale stages are permitted to propagate, masked only by REQ-026.

Reset
REQ-029 While rst_n=0 (asynchronous assertion), the following SHALL all be 0: shadow, active config, counter, cfg_err, cfg_so, sync flops, output/OE registers, fab_in.
REQ-030 Reset SHALL leave all pads hi-Z; deassertion SHALL take effect at the next clk edge.
REQ-031 Reset mid-shift SHALL discard the partial chain; a commit is then rejected until CW new bits are shifted.

Structure
REQ-032 Package io_block_pkg SHALL hold the mode encodings (MODE_OFF, MODE_IN, MODE_OUT, MODE_BIDIR) and CFG_BITS_PER_PAD=3.
REQ-033 Per-pad logic SHALL be sub-module io_pad_cell (mode/reg_out in, tristate driver, output regs, synchroniser), generated N_PADS times; the config chain/counter SHALL live in the top level.

Verification
REQ-034 Reset: after rst_n low, pad=zzz, fab_in=000, cfg_so=0, cfg_err=0.
REQ-035 N=3: shift 9 bits 000_010_001 (pad2..pad0) then commit -> pad1 drives fab_out[1] next cycle; pad0 value 1 appears on fab_in[0] after 2 cycles.
REQ-036 Shift 8 bits then commit -> cfg_err=1 and config unchanged; then shift 9 valid bits and commit -> cfg_err=0.
REQ-037 Pad0 = bidir with reg_out=1; toggle fab_oe 0->1, fab_out=1 -> pad0=1 exactly one cycle later; fab_in[0]=1 two cycles after that.
REQ-038 cfg_commit and cfg_en high together -> cfg_err=1 and the shift still occurs; cfg_so shows the shadow MSB, checked over 9 shifted cycles.
REQ-039 Assert rst_n low mid-shift after 4 bits -> pads go hi-Z immediately; a subsequent commit without reshift -> cfg_err=1.
